db_cont_assoc: RTL and testbench
================================

Name: db_cont_assoc

Overview:
- Successor to the direct-mapped key/value filter controller: a WAYS-way set-associative on-chip hash table for flow keys.
- Each entry holds a key, a value, a 4-bit flag (op/state) and an insertion timestamp. Entries age out after a programmable lifetime.
- Sits between the packet parser (hash/key/op/value) and the filter decision logic.
- Adds ready/valid back-pressure, post-reset table sweep, replacement on miss, and a response for every request.

Parameters:
- HASH_SIZE, 32, width of in_hash.
- KEY_SIZE, 96, key width.
- VAL_SIZE, 32, stored value width.
- INDEX_BITS, 10, set index width (sets = 2**INDEX_BITS), taken from in_hash[INDEX_BITS-1:0].
- WAYS, 4, associativity, 1..8.
- TS_W, 16, timestamp width.
- TICK_DIV, 16, clk cycles per timestamp tick (>=1).
- LIFETIME, 1000, entry lifetime in ticks (< 2**(TS_W-1)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  4  [0] SET=1/GET=0; [2:1] state IDLE=0, SUSPECT=1, ARREST=2, EXPIRE=3; [3] reserved, stored.
- in_hash  in  HASH_SIZE  precomputed key hash.
- in_key  in  KEY_SIZE  lookup key.
- in_value  in  VAL_SIZE  value for SET.
- out_valid  out  1  one-cycle response pulse.
- out_hit  out  1  live entry matched.
- out_flag  out  4  stored flag of the hit entry, else 0.
- out_value  out  VAL_SIZE  stored value of the hit entry, else 0.
- stat_evict  out  32  saturating count of live-entry evictions.

Behaviour:
- Reset (async assert, sync release): all outputs 0, in_ready=0, FSM=INIT, tick prescaler and timestamp `now` = 0, stat_evict = 0.
- INIT: one set per cycle clears every way's valid bit, index 0..2**INDEX_BITS-1. Then IDLE.
- Tick: prescaler counts 0..TICK_DIV-1; `now` increments on wrap, modulo 2**TS_W. It runs in every state including INIT.
- Handshake:
  - in_ready=1 only in IDLE. Accept = in_valid & in_ready.
  - op, hash index, key and value are registered on accept. Inputs are don't-care afterwards.
- FSM IDLE -> READ -> CMP -> (WRITE) -> RESP -> IDLE:
  - READ: synchronous read of all WAYS entries at the index.
  - CMP: per-way hit = valid & key equal.
    - live = hit & ((now - ts) mod 2**TS_W) < LIFETIME (wrap-safe unsigned subtract).
    - Multiple hits are impossible by construction. If they occur anyway, the lowest way wins.
  - GET: no write, go to RESP.
  - SET on live hit:
    - state IDLE: clear valid (delete).
    - SUSPECT: rewrite only if the stored flag state is not ARREST.
    - ARREST: rewrite.
    - EXPIRE: no change.
  - SET on miss or expired hit (except EXPIRE/IDLE ops, which are no-ops):
    - An expired hit reuses its own way.
    - Otherwise the victim is the first invalid way, else the first expired way, else the way with the greatest age, ties to the lowest way.
    - Evicting a valid, unexpired entry increments stat_evict, saturating at 2**32-1.
  - WRITE stores {valid=1, key, flag=in_op, value, ts=now}.
  - RESP:
    - out_valid=1 for exactly one cycle.
    - out_hit = live hit observed in CMP. out_flag/out_value are the pre-update stored contents on a hit, 0 otherwise.
    - out_* return to 0 the next cycle.
- Latency: accept at cycle 0 gives out_valid at cycle 3 (no write) or cycle 4 (write). Maximum throughput is one request per 4 or 5 cycles.
- A request arriving during INIT or a busy state is held by the source (in_ready=0). It is never dropped.
- Reset mid-operation aborts any pending write and restarts INIT.

Decomposition:
- Package db_pkg: op bit positions, state encodings (IDLE/SUSPECT/ARREST/EXPIRE), FSM state encoding, entry record layout {valid, key, flag, value, ts}.
- Sub-module db_victim_sel (combinational): valid/expired/age vectors in, victim way index out.

Test Plan:
- Reset, in_valid held high -> in_ready stays 0 for 1024 cycles after INIT entry, then rises; first request is accepted only then.
- SET key A, op=ARREST (4'b0101), value 0x1234, then GET A -> out_hit=1, out_flag=4'b0101, out_value=0x1234, out_valid 3 cycles after accept.
- Fill 5 keys sharing index 7 with WAYS=4, no expiry -> the 5th SET evicts the oldest; stat_evict=1; GET of the oldest misses (out_hit=0, out_flag=0).
- SET A; advance LIFETIME ticks (TICK_DIV=16, so 16000 cycles) -> GET A gives out_hit=0; a new SET to that set reuses A's way, stat_evict unchanged.
- SET A ARREST, then SET A SUSPECT -> the response shows flag 4'b0101; a later GET still returns 4'b0101 (no downgrade).
- Timestamp wrap: set TS_W=8, SET at now=250, GET at now=4 with LIFETIME=20 -> out_hit=1 (age 10).

Source files
------------

// File: rtl/db_pkg.sv
// Shared encodings for the set-associative flow table: op fields, flow states,
// controller FSM states and the stored entry layout.
package db_pkg;

    localparam int OP_SET_BIT = 0;
    localparam int OP_ST_LSB  = 1;
    localparam int OP_ST_MSB  = 2;
    localparam int OP_RSV_BIT = 3;
    localparam int FLAG_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ARREST  = 2'd2,
        ST_EXPIRE  = 2'd3
    } flow_state_e;

    typedef enum logic [2:0] {
        FSM_INIT  = 3'd0,
        FSM_IDLE  = 3'd1,
        FSM_READ  = 3'd2,
        FSM_CMP   = 3'd3,
        FSM_WRITE = 3'd4,
        FSM_RESP  = 3'd5
    } fsm_state_e;

    // Entry record is packed MSB..LSB as {valid, key, flag, value, ts}.
    function automatic int entry_width(input int key_w, input int val_w, input int ts_w);
        return 1 + key_w + FLAG_W + val_w + ts_w;
    endfunction

    function automatic flow_state_e op_state(input logic [FLAG_W-1:0] op);
        return flow_state_e'(op[OP_ST_MSB:OP_ST_LSB]);
    endfunction

endpackage

// File: rtl/db_victim_sel.sv
// Replacement choice for a miss: first invalid way, else first expired way,
// else the oldest way with ties going to the lowest index.
module db_victim_sel #(
    parameter  int WAYS = 4,
    parameter  int TS_W = 16,
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]      valid,
    input  logic [WAYS-1:0]      expired,
    input  logic [WAYS*TS_W-1:0] age,
    output logic [WW-1:0]        victim
);

    logic            found_inv;
    logic            found_exp;
    logic [WW-1:0]   inv_way;
    logic [WW-1:0]   exp_way;
    logic [WW-1:0]   old_way;
    logic [TS_W-1:0] old_age;

    always_comb begin
        found_inv = 1'b0;
        found_exp = 1'b0;
        inv_way   = '0;
        exp_way   = '0;
        old_way   = '0;
        old_age   = age[TS_W-1:0];
        // Descending scan so the lowest matching way is the last one written.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                found_inv = 1'b1;
                inv_way   = WW'(i);
            end
            if (valid[i] && expired[i]) begin
                found_exp = 1'b1;
                exp_way   = WW'(i);
            end
        end
        for (int i = 1; i < WAYS; i++) begin
            if (age[i*TS_W +: TS_W] > old_age) begin
                old_age = age[i*TS_W +: TS_W];
                old_way = WW'(i);
            end
        end
        if (found_inv) begin
            victim = inv_way;
        end else if (found_exp) begin
            victim = exp_way;
        end else begin
            victim = old_way;
        end
    end

endmodule

// File: rtl/db_cont_assoc.sv
// WAYS-way set-associative flow table with lifetime-based ageing,
// ready/valid request intake and one response pulse per request.
module db_cont_assoc
    import db_pkg::*;
#(
    parameter int HASH_SIZE  = 32,
    parameter int KEY_SIZE   = 96,
    parameter int VAL_SIZE   = 32,
    parameter int INDEX_BITS = 10,
    parameter int WAYS       = 4,
    parameter int TS_W       = 16,
    parameter int TICK_DIV   = 16,
    parameter int LIFETIME   = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [HASH_SIZE-1:0] in_hash,
    input  logic [KEY_SIZE-1:0]  in_key,
    input  logic [VAL_SIZE-1:0]  in_value,
    output logic                 out_valid,
    output logic                 out_hit,
    output logic [3:0]           out_flag,
    output logic [VAL_SIZE-1:0]  out_value,
    output logic [31:0]          stat_evict
);

    localparam int SETS = 2 ** INDEX_BITS;
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW   = entry_width(KEY_SIZE, VAL_SIZE, TS_W);

    typedef struct packed {
        logic                valid;
        logic [KEY_SIZE-1:0] key;
        logic [FLAG_W-1:0]   flag;
        logic [VAL_SIZE-1:0] value;
        logic [TS_W-1:0]     ts;
    } entry_t;

    fsm_state_e state_reg, state_next;

    logic [INDEX_BITS-1:0] init_idx_reg;
    logic [INDEX_BITS-1:0] idx_reg;
    logic [PW-1:0]         presc_reg;
    logic [TS_W-1:0]       now_reg;
    logic [3:0]            op_reg;
    logic [KEY_SIZE-1:0]   key_reg;
    logic [VAL_SIZE-1:0]   val_reg;
    logic [WW-1:0]         wr_way_reg;
    logic                  wr_del_reg;
    logic                  wr_evict_reg;
    logic                  resp_hit_reg;
    logic [3:0]            resp_flag_reg;
    logic [VAL_SIZE-1:0]   resp_val_reg;
    logic [31:0]           stat_reg;

    entry_t                rd_ent [WAYS];
    logic [WAYS-1:0]       vld_vec;
    logic [WAYS-1:0]       hit_vec;
    logic [WAYS-1:0]       exp_vec;
    logic [WAYS*TS_W-1:0]  age_flat;
    logic [WW-1:0]         victim;

    logic [WAYS-1:0]       way_we;
    logic [INDEX_BITS-1:0] mem_addr;
    entry_t                mem_wdata;

    logic                  any_hit;
    logic [WW-1:0]         hit_way;
    logic                  live;
    logic                  do_wr;
    logic                  do_del;
    logic                  do_evict;
    logic [WW-1:0]         tgt_way;
    flow_state_e           req_state;
    flow_state_e           stored_state;

    logic                  unused_hash_hi;
    assign unused_hash_hi = ^in_hash[HASH_SIZE-1:INDEX_BITS];

    // Table storage: one RAM per way, cleared by INIT, read-registered in READ.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            entry_t          mem [SETS];
            entry_t          rd_q;
            logic [TS_W-1:0] age_w;

            always_ff @(posedge clk) begin
                if (way_we[gi]) begin
                    mem[mem_addr] <= mem_wdata;
                end
                if (state_reg == FSM_READ) begin
                    rd_q <= mem[idx_reg];
                end
            end

            assign rd_ent[gi]                 = rd_q;
            assign age_w                      = now_reg - rd_q.ts;
            assign vld_vec[gi]                = rd_q.valid;
            assign hit_vec[gi]                = rd_q.valid && (rd_q.key == key_reg);
            assign exp_vec[gi]                = (age_w >= TS_W'(LIFETIME));
            assign age_flat[gi*TS_W +: TS_W]  = age_w;
        end
    endgenerate

    db_victim_sel #(
        .WAYS (WAYS),
        .TS_W (TS_W)
    ) u_victim (
        .valid   (vld_vec),
        .expired (exp_vec),
        .age     (age_flat),
        .victim  (victim)
    );

    always_comb begin
        mem_addr  = (state_reg == FSM_INIT) ? init_idx_reg : idx_reg;
        mem_wdata = (state_reg == FSM_INIT) ? entry_t'('0)
                  : entry_t'({~wr_del_reg, key_reg, op_reg, val_reg, now_reg});
        for (int i = 0; i < WAYS; i++) begin
            way_we[i] = (state_reg == FSM_INIT) ||
                        ((state_reg == FSM_WRITE) && (wr_way_reg == WW'(i)));
        end
    end

    // Lookup outcome and update decision, meaningful during CMP.
    always_comb begin
        any_hit = 1'b0;
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                hit_way = WW'(i);
            end
        end
        live         = any_hit && !exp_vec[hit_way];
        req_state    = op_state(op_reg);
        stored_state = op_state(rd_ent[hit_way].flag);
        do_wr        = 1'b0;
        do_del       = 1'b0;
        do_evict     = 1'b0;
        tgt_way      = hit_way;
        if (op_reg[OP_SET_BIT]) begin
            if (live) begin
                case (req_state)
                    ST_IDLE: begin
                        do_wr  = 1'b1;
                        do_del = 1'b1;
                    end
                    ST_SUSPECT: do_wr = (stored_state != ST_ARREST);
                    ST_ARREST:  do_wr = 1'b1;
                    default:    do_wr = 1'b0;
                endcase
            end else if ((req_state == ST_SUSPECT) || (req_state == ST_ARREST)) begin
                do_wr    = 1'b1;
                tgt_way  = any_hit ? hit_way : victim;
                do_evict = vld_vec[tgt_way] && !exp_vec[tgt_way];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_hit    = 1'b0;
        out_flag   = '0;
        out_value  = '0;
        case (state_reg)
            FSM_INIT: begin
                if (init_idx_reg == '1) begin
                    state_next = FSM_IDLE;
                end
            end
            FSM_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = FSM_READ;
                end
            end
            FSM_READ:  state_next = FSM_CMP;
            FSM_CMP:   state_next = do_wr ? FSM_WRITE : FSM_RESP;
            FSM_WRITE: state_next = FSM_RESP;
            FSM_RESP: begin
                out_valid  = 1'b1;
                out_hit    = resp_hit_reg;
                out_flag   = resp_flag_reg;
                out_value  = resp_val_reg;
                state_next = FSM_IDLE;
            end
            default:   state_next = FSM_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FSM_INIT;
            init_idx_reg  <= '0;
            idx_reg       <= '0;
            presc_reg     <= '0;
            now_reg       <= '0;
            op_reg        <= '0;
            key_reg       <= '0;
            val_reg       <= '0;
            wr_way_reg    <= '0;
            wr_del_reg    <= 1'b0;
            wr_evict_reg  <= 1'b0;
            resp_hit_reg  <= 1'b0;
            resp_flag_reg <= '0;
            resp_val_reg  <= '0;
            stat_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (presc_reg == PW'(TICK_DIV - 1)) begin
                presc_reg <= '0;
                now_reg   <= now_reg + 1'b1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            if (state_reg == FSM_INIT) begin
                init_idx_reg <= init_idx_reg + 1'b1;
            end
            if ((state_reg == FSM_IDLE) && in_valid) begin
                op_reg  <= in_op;
                idx_reg <= in_hash[INDEX_BITS-1:0];
                key_reg <= in_key;
                val_reg <= in_value;
            end
            if (state_reg == FSM_CMP) begin
                wr_way_reg    <= tgt_way;
                wr_del_reg    <= do_del;
                wr_evict_reg  <= do_evict;
                resp_hit_reg  <= live;
                resp_flag_reg <= live ? rd_ent[hit_way].flag  : '0;
                resp_val_reg  <= live ? rd_ent[hit_way].value : '0;
            end
            if ((state_reg == FSM_WRITE) && wr_evict_reg && (stat_reg != '1)) begin
                stat_reg <= stat_reg + 1'b1;
            end
        end
    end

    assign stat_evict = stat_reg;

endmodule

// File: tb/tb_db_cont_assoc.sv
// Directed bench: a default-sized table plus a small 8-bit-timestamp table
// for the wrap case, driven from a shared request bus.
module tb_db_cont_assoc;

    localparam logic [3:0] OP_GET  = 4'b0000;
    localparam logic [3:0] OP_SIDL = 4'b0001;
    localparam logic [3:0] OP_SSUS = 4'b0011;
    localparam logic [3:0] OP_SARR = 4'b0101;
    localparam logic [3:0] OP_SEXP = 4'b0111;

    localparam logic [95:0] KA  = 96'hA;
    localparam logic [95:0] KB  = 96'hB;
    localparam logic [95:0] K1  = 96'h101;
    localparam logic [95:0] K2  = 96'h102;
    localparam logic [95:0] K3  = 96'h103;
    localparam logic [95:0] K4  = 96'h104;
    localparam logic [95:0] K5  = 96'h8000_0000_0000_0000_0000_0101;
    localparam logic [95:0] KA2 = 96'hA2;
    localparam logic [95:0] KB2 = 96'hB2;
    localparam logic [95:0] KC2 = 96'hC2;
    localparam logic [95:0] KD2 = 96'hD2;
    localparam logic [95:0] KE2 = 96'hE2;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] hash;
        logic [95:0] key;
        logic [31:0] val;
        logic        hit;
        logic [3:0]  flag;
        logic [31:0] oval;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        va = 1'b0, vb = 1'b0;
    logic [3:0]  in_op = '0;
    logic [31:0] in_hash = '0;
    logic [95:0] in_key = '0;
    logic [31:0] in_value = '0;

    logic        rdy_a, ov_a, hit_a, rdy_b, ov_b, hit_b;
    logic [3:0]  flag_a, flag_b;
    logic [31:0] val_a, val_b, stat_a, stat_b;

    int n_chk = 0;
    int n_fail = 0;
    int unsigned c2;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c2 <= 0;
        else        c2 <= c2 + 1;
    end

    db_cont_assoc u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a),
        .in_op(in_op), .in_hash(in_hash), .in_key(in_key), .in_value(in_value),
        .out_valid(ov_a), .out_hit(hit_a), .out_flag(flag_a), .out_value(val_a),
        .stat_evict(stat_a)
    );

    db_cont_assoc #(.INDEX_BITS(4), .TS_W(8), .TICK_DIV(4), .LIFETIME(20)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b),
        .in_op(in_op), .in_hash(in_hash), .in_key(in_key), .in_value(in_value),
        .out_valid(ov_b), .out_hit(hit_b), .out_flag(flag_b), .out_value(val_b),
        .stat_evict(stat_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic ovl(input int inst);
        return (inst == 0) ? ov_a : ov_b;
    endfunction

    // One request: wait for ready, count cycles to the response, check it and the pulse end.
    task automatic run(input string nm, input int inst, input vec_t v);
        logic        h;
        logic [3:0]  f;
        logic [31:0] o;
        int          lat;
        int          n;
        in_op = v.op; in_hash = v.hash; in_key = v.key; in_value = v.val;
        if (inst == 0) va = 1'b1; else vb = 1'b1;
        n = 0;
        while (!rdy(inst) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".ready"}, 32'(rdy(inst)), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            va = 1'b0; vb = 1'b0;
            lat++;
        end while (!ovl(inst) && lat < 10);
        h = (inst == 0) ? hit_a  : hit_b;
        f = (inst == 0) ? flag_a : flag_b;
        o = (inst == 0) ? val_a  : val_b;
        $display("%s: op=%b key=%0h val=%0h -> hit=%0d flag=%b value=%0h lat=%0d",
                 nm, v.op, v.key, v.val, h, f, o, lat);
        chk({nm, ".hit"},   32'(h), 32'(v.hit));
        chk({nm, ".flag"},  32'(f), 32'(v.flag));
        chk({nm, ".value"}, o, v.oval);
        chk({nm, ".lat"},   32'(lat), 32'(v.lat));
        @(negedge clk);
        chk({nm, ".pulse"}, 32'({ovl(inst), (inst == 0) ? hit_a : hit_b}), 32'd0);
    endtask

    task automatic wait_now2(input int target);
        int n;
        n = 0;
        while ((((c2 / 4) % 256) != target) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap.wait", 32'(((c2 / 4) % 256)), 32'(target));
    endtask

    vec_t tv [26];
    vec_t sv;
    int   cnt;

    initial begin
        tv[0]  = '{OP_SARR, 32'h3,          KA, 32'h1234, 1'b0, 4'h0, 32'h0,    4};
        tv[1]  = '{OP_GET,  32'h3,          KA, 32'h0,    1'b1, 4'h5, 32'h1234, 3};
        tv[2]  = '{OP_SSUS, 32'h3,          KA, 32'h5555, 1'b1, 4'h5, 32'h1234, 3};
        tv[3]  = '{OP_GET,  32'h3,          KA, 32'h0,    1'b1, 4'h5, 32'h1234, 3};
        tv[4]  = '{OP_SARR, 32'h3,          KA, 32'h9999, 1'b1, 4'h5, 32'h1234, 4};
        tv[5]  = '{OP_GET,  32'h3,          KA, 32'h0,    1'b1, 4'h5, 32'h9999, 3};
        tv[6]  = '{OP_SIDL, 32'h3,          KA, 32'h0,    1'b1, 4'h5, 32'h9999, 4};
        tv[7]  = '{OP_GET,  32'h3,          KA, 32'h0,    1'b0, 4'h0, 32'h0,    3};
        tv[8]  = '{OP_SEXP, 32'h3,          KA, 32'h42,   1'b0, 4'h0, 32'h0,    3};
        tv[9]  = '{OP_GET,  32'h3,          KA, 32'h0,    1'b0, 4'h0, 32'h0,    3};
        tv[10] = '{OP_SIDL, 32'h3,          KA, 32'h1,    1'b0, 4'h0, 32'h0,    3};
        tv[11] = '{OP_SSUS, 32'h3,          KB, 32'h77,   1'b0, 4'h0, 32'h0,    4};
        tv[12] = '{OP_SSUS, 32'h3,          KB, 32'h88,   1'b1, 4'h3, 32'h77,   4};
        tv[13] = '{4'hD,    32'h3,          KB, 32'h1,    1'b1, 4'h3, 32'h88,   4};
        tv[14] = '{OP_GET,  32'h3,          KB, 32'h0,    1'b1, 4'hD, 32'h1,    3};
        tv[15] = '{OP_GET,  32'h3,          KA, 32'h0,    1'b0, 4'h0, 32'h0,    3};
        tv[16] = '{OP_SARR, 32'h0000_0007,  K1, 32'h11,   1'b0, 4'h0, 32'h0,    4};
        tv[17] = '{OP_SARR, 32'hFFFF_FC07,  K2, 32'h12,   1'b0, 4'h0, 32'h0,    4};
        tv[18] = '{OP_SARR, 32'h1234_0407,  K3, 32'h13,   1'b0, 4'h0, 32'h0,    4};
        tv[19] = '{OP_SARR, 32'h0000_0C07,  K4, 32'h14,   1'b0, 4'h0, 32'h0,    4};
        tv[20] = '{OP_SARR, 32'h8000_0007,  K5, 32'h15,   1'b0, 4'h0, 32'h0,    4};
        tv[21] = '{OP_GET,  32'h7,          K1, 32'h0,    1'b0, 4'h0, 32'h0,    3};
        tv[22] = '{OP_GET,  32'h7,          K2, 32'h0,    1'b1, 4'h5, 32'h12,   3};
        tv[23] = '{OP_GET,  32'h7,          K4, 32'h0,    1'b1, 4'h5, 32'h14,   3};
        tv[24] = '{OP_GET,  32'h7,          K5, 32'h0,    1'b1, 4'h5, 32'h15,   3};
        tv[25] = '{OP_GET,  32'h7,          K3, 32'h0,    1'b1, 4'h5, 32'h13,   3};

        // Reset with a request already pending on the bus.
        in_op = OP_GET; in_hash = 32'h3; in_key = KA; in_value = '0;
        va = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.in_ready",  32'(rdy_a),  32'd0);
        chk("rst.out_valid", 32'(ov_a),   32'd0);
        chk("rst.out_hit",   32'(hit_a),  32'd0);
        chk("rst.out_flag",  32'(flag_a), 32'd0);
        chk("rst.out_value", val_a,       32'd0);
        chk("rst.stat",      stat_a,      32'd0);
        rst_n = 1'b1;
        cnt = 0;
        while (!rdy_a && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        $display("init: in_ready rose after %0d cycles", cnt);
        chk("init.cycles", 32'(cnt), 32'd1024);
        sv = '{OP_GET, 32'h3, KA, 32'h0, 1'b0, 4'h0, 32'h0, 3};
        run("held_get", 0, sv);

        for (int i = 0; i < 26; i++) begin
            run($sformatf("vec%0d", i), 0, tv[i]);
        end
        chk("evict.stat", stat_a, 32'd1);

        // Lifetime expiry: A2 ages out, then a new key takes its way without an eviction.
        sv = '{OP_SARR, 32'h9, KA2, 32'h21, 1'b0, 4'h0, 32'h0, 4}; run("exp.set_a2", 0, sv);
        repeat (16100) @(negedge clk);
        sv = '{OP_SARR, 32'h9, KB2, 32'h22, 1'b0, 4'h0, 32'h0, 4}; run("exp.set_b2", 0, sv);
        sv = '{OP_SARR, 32'h9, KC2, 32'h23, 1'b0, 4'h0, 32'h0, 4}; run("exp.set_c2", 0, sv);
        sv = '{OP_SARR, 32'h9, KD2, 32'h24, 1'b0, 4'h0, 32'h0, 4}; run("exp.set_d2", 0, sv);
        sv = '{OP_GET,  32'h9, KA2, 32'h0,  1'b0, 4'h0, 32'h0, 3}; run("exp.get_a2", 0, sv);
        sv = '{OP_SARR, 32'h9, KE2, 32'h25, 1'b0, 4'h0, 32'h0, 4}; run("exp.set_e2", 0, sv);
        chk("exp.stat", stat_a, 32'd1);
        sv = '{OP_GET,  32'h9, KB2, 32'h0,  1'b1, 4'h5, 32'h22, 3}; run("exp.get_b2", 0, sv);
        sv = '{OP_GET,  32'h9, KD2, 32'h0,  1'b1, 4'h5, 32'h24, 3}; run("exp.get_d2", 0, sv);
        sv = '{OP_GET,  32'h9, KE2, 32'h0,  1'b1, 4'h5, 32'h25, 3}; run("exp.get_e2", 0, sv);
        sv = '{OP_SARR, 32'h3, KB,  32'h77, 1'b0, 4'h0, 32'h0,  4}; run("exp.reuse_b", 0, sv);
        sv = '{OP_GET,  32'h3, KB,  32'h0,  1'b1, 4'h5, 32'h77, 3}; run("exp.get_b", 0, sv);
        chk("exp.stat2", stat_a, 32'd1);

        // Timestamp wrap on the 8-bit table: written near 250, read back near 4 and 30.
        wait_now2(249);
        sv = '{OP_SARR, 32'h3, KA, 32'hAB, 1'b0, 4'h0, 32'h0,  4}; run("wrap.set", 1, sv);
        wait_now2(4);
        sv = '{OP_GET,  32'h3, KA, 32'h0,  1'b1, 4'h5, 32'hAB, 3}; run("wrap.get_live", 1, sv);
        wait_now2(30);
        sv = '{OP_GET,  32'h3, KA, 32'h0,  1'b0, 4'h0, 32'h0,  3}; run("wrap.get_old", 1, sv);
        chk("wrap.stat", stat_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
